branch_resolve_predict: RTL and testbench

- Execute-stage branch resolution unit with a fetch-stage branch predictor, for the pipelined RV32I core.
- Resolves all six conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) plus jumps.
- Maintains a PC-indexed table of 2-bit saturating counters and flags mispredictions so hazard logic can flush and redirect.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_resolve_predict.sv | 98 +++++++++
 tb/tb_branch_resolve_predict.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predict.sv
// Execute-stage branch resolution with a PC-indexed 2-bit counter predictor.
// Flags mispredictions for flush/redirect and keeps saturating branch statistics.
module branch_resolve_predict #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned INDEX_LSB   = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCF,
    output logic                  PredTakenF,
    input  logic                  BranchE,
    input  logic                  JumpE,
    input  logic [2:0]            funct3E,
    input  logic                  ZeroE,
    input  logic                  LtE,
    input  logic                  LtuE,
    input  logic [ADDR_WIDTH-1:0] PCE,
    input  logic                  PredTakenE,
    output logic                  PCSrcE,
    output logic                  MispredictE,
    output logic                  RedirectSelE,
    output logic                  IllegalBranchE,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  MispredCount
);

    localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

    logic [1:0]      bht [BHT_ENTRIES];
    logic [IDXW-1:0] idx_f;
    logic [IDXW-1:0] idx_e;
    logic            taken_c;
    logic            legal_c;
    logic            branch_only_c;
    logic            update_c;
    logic            unused_pc;

    assign idx_f     = PCF[INDEX_LSB +: IDXW];
    assign idx_e     = PCE[INDEX_LSB +: IDXW];
    assign unused_pc = ^{PCF, PCE};

    // Read is the pre-update value; no same-cycle bypass.
    assign PredTakenF = bht[idx_f][1];

    // Branch condition decode
    always_comb begin
        taken_c = 1'b0;
        legal_c = 1'b1;
        case (funct3E)
            3'b000:  taken_c = ZeroE;
            3'b001:  taken_c = ~ZeroE;
            3'b100:  taken_c = LtE;
            3'b101:  taken_c = ~LtE;
            3'b110:  taken_c = LtuE;
            3'b111:  taken_c = ~LtuE;
            default: legal_c = 1'b0;
        endcase
    end

    // A jump with BranchE also set is resolved purely as a jump.
    assign branch_only_c = BranchE & ~JumpE;
    assign update_c      = branch_only_c & legal_c & ~rst;

    assign PCSrcE         = ~rst & (JumpE | (branch_only_c & taken_c));
    assign MispredictE    = ~rst & (JumpE | (branch_only_c & legal_c & (taken_c != PredTakenE)));
    assign RedirectSelE   = PCSrcE;
    assign IllegalBranchE = ~rst & branch_only_c & ~legal_c;

    // Counter table: reset to weak-not-taken, saturating train on resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (update_c) begin
            if (taken_c) begin
                if (bht[idx_e] != 2'b11) bht[idx_e] <= bht[idx_e] + 2'd1;
            end else begin
                if (bht[idx_e] != 2'b00) bht[idx_e] <= bht[idx_e] - 2'd1;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else if (update_c) begin
            if (BranchCount != '1) BranchCount <= BranchCount + CNT_WIDTH'(1);
            if ((taken_c != PredTakenE) && (MispredCount != '1))
                MispredCount <= MispredCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict: expected outputs are queued
// at drive time from a reference predictor model and popped when sampled.
module tb_branch_resolve_predict;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   PCF;
    logic          PredTakenF;
    logic          BranchE;
    logic          JumpE;
    logic [2:0]    funct3E;
    logic          ZeroE;
    logic          LtE;
    logic          LtuE;
    logic [31:0]   PCE;
    logic          PredTakenE;
    logic          PCSrcE;
    logic          MispredictE;
    logic          RedirectSelE;
    logic          IllegalBranchE;
    logic [CW-1:0] BranchCount;
    logic [CW-1:0] MispredCount;

    branch_resolve_predict #(
        .ADDR_WIDTH (32),
        .BHT_ENTRIES(64),
        .INDEX_LSB  (2),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCF           (PCF),
        .PredTakenF    (PredTakenF),
        .BranchE       (BranchE),
        .JumpE         (JumpE),
        .funct3E       (funct3E),
        .ZeroE         (ZeroE),
        .LtE           (LtE),
        .LtuE          (LtuE),
        .PCE           (PCE),
        .PredTakenE    (PredTakenE),
        .PCSrcE        (PCSrcE),
        .MispredictE   (MispredictE),
        .RedirectSelE  (RedirectSelE),
        .IllegalBranchE(IllegalBranchE),
        .BranchCount   (BranchCount),
        .MispredCount  (MispredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        logic  pcsrc;
        logic  mis;
        logic  redir;
        logic  ill;
        logic  predf;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_bht [64];
    int   m_bc;
    int   m_mc;

    function automatic int pidx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic pred(input logic [31:0] pc);
        return (m_bht[pidx(pc)] >= 2);
    endfunction

    // One execute cycle: queue expectations, sample mid-cycle, clock, update model
    task automatic do_cycle(input string nm, input logic r, input logic br, input logic jp,
                            input logic [2:0] f3, input logic z, input logic lt,
                            input logic ltu, input logic [31:0] pce, input logic pe,
                            input logic [31:0] pcf);
        exp_t e;
        exp_t g;
        logic tk;
        logic legal;
        logic bo;
        rst = r; BranchE = br; JumpE = jp; funct3E = f3; ZeroE = z; LtE = lt;
        LtuE = ltu; PCE = pce; PredTakenE = pe; PCF = pcf;
        legal = !(f3 == 3'b010 || f3 == 3'b011);
        case (f3)
            3'b000:  tk = z;
            3'b001:  tk = !z;
            3'b100:  tk = lt;
            3'b101:  tk = !lt;
            3'b110:  tk = ltu;
            3'b111:  tk = !ltu;
            default: tk = 1'b0;
        endcase
        bo      = br && !jp;
        e.nm    = nm;
        e.pcsrc = !r && (jp || (bo && tk));
        e.mis   = !r && (jp || (bo && legal && (tk != pe)));
        e.redir = e.pcsrc;
        e.ill   = !r && bo && !legal;
        e.predf = pred(pcf);
        q.push_back(e);
        #1;
        g = q.pop_front();
        checks += 5;
        if (PCSrcE !== g.pcsrc) begin
            errors++; $display("FAIL %s PCSrcE got %b exp %b", g.nm, PCSrcE, g.pcsrc);
        end
        if (MispredictE !== g.mis) begin
            errors++; $display("FAIL %s MispredictE got %b exp %b", g.nm, MispredictE, g.mis);
        end
        if (RedirectSelE !== g.redir) begin
            errors++; $display("FAIL %s RedirectSelE got %b exp %b", g.nm, RedirectSelE, g.redir);
        end
        if (IllegalBranchE !== g.ill) begin
            errors++; $display("FAIL %s IllegalBranchE got %b exp %b", g.nm, IllegalBranchE, g.ill);
        end
        if (PredTakenF !== g.predf) begin
            errors++; $display("FAIL %s PredTakenF got %b exp %b", g.nm, PredTakenF, g.predf);
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (bo && legal) begin
            if (tk && m_bht[pidx(pce)] < 3) m_bht[pidx(pce)]++;
            if (!tk && m_bht[pidx(pce)] > 0) m_bht[pidx(pce)]--;
            if (m_bc < 15) m_bc++;
            if (tk != pe && m_mc < 15) m_mc++;
        end
        #1;
    endtask

    task automatic idle(input string nm, input logic [31:0] pcf);
        do_cycle(nm, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, pcf);
    endtask

    task automatic check_stats(input string nm);
        checks += 2;
        if (BranchCount !== CW'(m_bc)) begin
            errors++; $display("FAIL %s BranchCount got %0d exp %0d", nm, BranchCount, m_bc);
        end
        if (MispredCount !== CW'(m_mc)) begin
            errors++; $display("FAIL %s MispredCount got %0d exp %0d", nm, MispredCount, m_mc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; BranchE = 1'b0; JumpE = 1'b0; funct3E = 3'b000; ZeroE = 1'b0;
        LtE = 1'b0; LtuE = 1'b0; PCE = '0; PredTakenE = 1'b0; PCF = 32'h100;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
        m_bc = 0;
        m_mc = 0;
        idle("reset_pcf100", 32'h100);
        check_stats("reset_stats");
    endtask

    task automatic test_beq_train();
        logic p;
        p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle($sformatf("beq_train%0d", i), 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0,
                     1'b0, 32'h100, p, 32'h100);
            p = pred(32'h100);
        end
        idle("beq_trained_pred", 32'h100);
        check_stats("beq_stats");
    endtask

    task automatic test_compare();
        // lt=1, ltu=0: signed and unsigned compares disagree
        do_cycle("blt",  1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 32'h404, 1'b0, 32'h404);
        do_cycle("bltu", 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1, 1'b0, 32'h408, 1'b0, 32'h404);
        do_cycle("bge",  1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 32'h40c, 1'b1, 32'h408);
        do_cycle("bgeu", 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 32'h410, 1'b1, 32'h40c);
        do_cycle("bne_z0", 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h414, 1'b1, 32'h410);
        do_cycle("beq_z0", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h418, 1'b0, 32'h414);
        check_stats("compare_stats");
    endtask

    task automatic test_jump_priority();
        do_cycle("jump_and_branch", 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h420,
                 1'b0, 32'h420);
        do_cycle("jump_only", 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h420,
                 1'b0, 32'h420);
        idle("jump_no_train", 32'h420);
        check_stats("jump_stats");
    endtask

    task automatic test_illegal();
        do_cycle("illegal_010", 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h424,
                 1'b1, 32'h424);
        do_cycle("illegal_011", 1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 32'h424,
                 1'b0, 32'h424);
        idle("illegal_no_train", 32'h424);
        check_stats("illegal_stats");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pce;
        logic [31:0] pcf;
        logic [2:0]  f3;
        for (int i = 0; i < 30; i++) begin
            pce = 32'h100 + 32'(($urandom % 4) << 2);
            pcf = 32'h100 + 32'(($urandom % 4) << 2);
            f3  = 3'($urandom % 8);
            do_cycle($sformatf("b2b%0d", i), 1'b0, 1'($urandom % 2), 1'(($urandom % 5) == 0),
                     f3, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), pce,
                     (($urandom % 2) != 0) ? pred(pce) : 1'($urandom % 2), pcf);
        end
        check_stats("b2b_stats");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            do_cycle($sformatf("sat%0d", i), 1'b0, 1'b1, 1'b0, 3'b001, 1'($urandom % 2),
                     1'b0, 1'b0, 32'h500, 1'($urandom % 2), 32'h500);
        end
        check_stats("sat_stats");
    endtask

    task automatic test_reset_midstream();
        // Mispredicted taken BEQ issued while reset is asserted
        do_cycle("rst_mispred", 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100,
                 1'b0, 32'h100);
        check_stats("rst_mid_stats");
        idle("rst_mid_entry_nt", 32'h100);
        do_cycle("post_rst_train", 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100,
                 1'b0, 32'h100);
        idle("post_rst_weak_t", 32'h100);
        check_stats("post_rst_stats");
    endtask

    initial begin
        test_reset();
        test_beq_train();
        test_compare();
        test_jump_priority();
        test_illegal();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
